// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit layout and serializer state encoding.
package uart_tx_pkg;

    localparam logic [1:0] OFS_DATA   = 2'd0;
    localparam logic [1:0] OFS_STATUS = 2'd1;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // STATUS only has a 4-bit count field, so deeper FIFOs report 15.
    function automatic logic [3:0] sat_count(input int unsigned cnt);
        return (cnt > 32'd15) ? 4'hF : cnt[3:0];
    endfunction

endpackage

// File: rtl/uart_tx_periph_if.sv
// Processor data-bus signals seen by the UART transmitter; the CPU side is
// the master, the peripheral is the slave.
interface uart_tx_periph_if;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        sel;

    modport master (
        output mem_addr, mem_rstrb, mem_wdata, mem_wmask, sel,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_rstrb, mem_wdata, mem_wmask, sel,
        output mem_rdata
    );
endinterface

// File: rtl/uart_tx_periph_sync_fifo.sv
// Circular-buffer FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
        else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS registers, TX FIFO, baud
// counter and serializer.
//   state | meaning
//   IDLE  | line high; pops the FIFO head as soon as it is non-empty
//   START | start bit (0) for one bit period
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (1) for one bit period
module uart_tx_periph
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            resetn,
    uart_tx_periph_if.slave bus,
    output logic            TXD
);
    localparam int DIV  = CLK_FREQ_HZ / BAUD;
    localparam int CW   = $clog2(DIV);
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

    tx_state_e       state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic            ovf_q, ovf_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [1:0]      ofs;
    logic            rd, push, pop, ovf_evt, bit_end;
    logic            fifo_full, fifo_empty;
    logic [7:0]      fifo_dout;
    logic [CNTW-1:0] fifo_count;
    logic [31:0]     status;
    logic            unused_ok;

    assign ofs     = bus.mem_addr[3:2];
    assign rd      = bus.sel && bus.mem_rstrb;
    assign push    = bus.sel && bus.mem_wmask[0] && (ofs == OFS_DATA);
    assign ovf_evt = push && fifo_full && !pop;
    assign bit_end = (baud_q == BAUD_LAST);
    assign unused_ok = ^{bus.mem_addr[31:4], bus.mem_addr[1:0],
                         bus.mem_wdata[31:8], bus.mem_wmask[3:1]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (bus.mem_wdata[7:0]),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        status                      = '0;
        status[ST_BUSY]             = (state_q != IDLE);
        status[ST_FULL]             = fifo_full;
        status[ST_EMPTY]            = fifo_empty;
        status[ST_OVF]              = ovf_q;
        status[ST_CNT_LSB +: 4]     = sat_count(32'(fifo_count));
    end

    // An overflow in the same cycle as a STATUS read wins over the clear.
    always_comb begin
        rdata_d = rdata_q;
        ovf_d   = ovf_q;
        if (rd) rdata_d = (ofs == OFS_STATUS) ? status : '0;
        if (rd && ofs == OFS_STATUS) ovf_d = 1'b0;
        if (ovf_evt) ovf_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + CW'(1);
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    txd_d   = 1'b0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: if (bit_end) begin
                txd_d   = shift_q[0];
                bit_d   = 3'd0;
                state_d = DATA;
            end
            DATA: if (bit_end) begin
                if (bit_q == 3'd7) begin
                    txd_d   = 1'b1;
                    state_d = STOP;
                end else begin
                    shift_d = {1'b0, shift_q[7:1]};
                    txd_d   = shift_q[1];
                    bit_d   = bit_q + 3'd1;
                end
            end
            STOP: if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
        end
    end

    assign TXD           = txd_q;
    assign bus.mem_rdata = rdata_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed and random bench for uart_tx_periph with a timeline reference
// model of the FIFO/serializer and a line decoder on TXD.
module tb_uart_tx_periph;
    localparam int CLK_HZ = 1000000;
    localparam int BAUD_R = 100000;
    localparam int DIV    = CLK_HZ / BAUD_R;
    localparam int DEPTH  = 4;
    localparam int FRAME  = 10 * DIV;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic TXD;

    uart_tx_periph_if bus ();

    uart_tx_periph #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R), .FIFO_DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .TXD    (TXD)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: byte queue plus the edge at which the current frame began.
    int unsigned edge_n = 0;
    logic [7:0]  m_fifo[$];
    logic [7:0]  m_sent[$];
    bit          m_has = 1'b0;
    int unsigned m_pop_e = 0;
    logic [7:0]  m_pop_b = 8'h00;
    logic        m_ovf = 1'b0;
    logic [31:0] m_rdata = 32'h0;

    initial begin
        int unsigned e, cnt;
        logic busy, full, pop, push, rd;
        logic [1:0] ofs;
        logic [31:0] st;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_fifo.delete();
                m_sent.delete();
                m_has   = 1'b0;
                m_ovf   = 1'b0;
                m_rdata = 32'h0;
            end else begin
                edge_n++;
                e    = edge_n;
                cnt  = m_fifo.size();
                busy = m_has && (e <= m_pop_e + FRAME);
                full = (cnt == DEPTH);
                pop  = (cnt != 0) && !busy;
                ofs  = bus.mem_addr[3:2];
                push = bus.sel && bus.mem_wmask[0] && (ofs == 2'd0);
                rd   = bus.sel && bus.mem_rstrb;
                st   = 32'(((cnt > 15) ? 15 : cnt) * 16) + (m_ovf ? 32'd8 : 32'd0)
                     + ((cnt == 0) ? 32'd4 : 32'd0) + (full ? 32'd2 : 32'd0) + (busy ? 32'd1 : 32'd0);
                if (rd) m_rdata = (ofs == 2'd1) ? st : 32'h0;
                if (rd && ofs == 2'd1) m_ovf = 1'b0;
                if (pop) begin
                    m_pop_b = m_fifo.pop_front();
                    m_sent.push_back(m_pop_b);
                    m_pop_e = e;
                    m_has   = 1'b1;
                end
                if (push) begin
                    if (!full || pop) m_fifo.push_back(bus.mem_wdata[7:0]);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    function automatic logic exp_txd();
        int unsigned d, idx;
        if (!resetn || !m_has) return 1'b1;
        d = edge_n - m_pop_e;
        if (d >= FRAME) return 1'b1;
        idx = d / DIV;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_pop_b[idx - 1];
    endfunction

    initial forever begin
        @(negedge clk);
        chk("txd_line", 32'(TXD), 32'(exp_txd()));
        chk("rdata", bus.mem_rdata, m_rdata);
    end

    // Line decoder: samples each bit in the middle of its period.
    bit          dec_act = 1'b0;
    int          dec_cnt = 0;
    logic [7:0]  dec_byte = 8'h00;
    int unsigned dec_starts[$];
    logic [7:0]  dec_log[$];

    initial forever begin
        @(negedge clk);
        if (!resetn) begin
            dec_act = 1'b0;
        end else if (!dec_act) begin
            if (TXD == 1'b0) begin
                dec_act = 1'b1;
                dec_cnt = 0;
                dec_starts.push_back(edge_n);
            end
        end else begin
            dec_cnt++;
            if (dec_cnt % DIV == DIV / 2 && dec_cnt / DIV >= 1 && dec_cnt / DIV <= 8)
                dec_byte[dec_cnt / DIV - 1] = TXD;
            if (dec_cnt == 9 * DIV + DIV / 2) begin
                chk("rx_stop_bit", 32'(TXD), 32'd1);
                dec_log.push_back(dec_byte);
                if (m_sent.size() == 0) chk("rx_frame_expected", 32'(m_sent.size()), 32'd1);
                else chk("rx_byte", 32'(dec_byte), 32'(m_sent.pop_front()));
                dec_act = 1'b0;
            end
        end
    end

    task automatic bus_op(input logic rd, input logic wr, input logic [1:0] ofs, input logic [31:0] wd);
        bus.sel       = 1'b1;
        bus.mem_rstrb = rd;
        bus.mem_wmask = wr ? 4'hF : 4'h0;
        bus.mem_addr  = {28'h0, ofs, 2'b00};
        bus.mem_wdata = wd;
        @(negedge clk);
        bus.sel       = 1'b0;
        bus.mem_rstrb = 1'b0;
        bus.mem_wmask = 4'h0;
    endtask

    task automatic wait_edge(input int unsigned target);
        int n = 0;
        while (edge_n < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((m_fifo.size() != 0 || (m_has && edge_n < m_pop_e + FRAME + 2)) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain_bound"}, 32'(n < 4000), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int unsigned k;
        logic [7:0] b[6];
        bus.sel = 1'b0; bus.mem_rstrb = 1'b0; bus.mem_wmask = 4'h0;
        bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_txd", 32'(TXD), 32'd1);
        chk("reset_rdata", bus.mem_rdata, 32'h0);
        #2 resetn = 1'b1;
        @(negedge clk);
        bus_op(1'b1, 1'b0, 2'd1, 32'h0);
        chk("status_after_reset", bus.mem_rdata, 32'h04);

        // single 0x55 frame and busy boundary
        bus_op(1'b0, 1'b1, 2'd0, 32'h55);
        k = edge_n;
        chk("t1_txd_before", 32'(TXD), 32'd1);
        @(negedge clk);
        chk("t1_start_bit", 32'(TXD), 32'd0);
        wait_edge(k + 100);
        bus_op(1'b1, 1'b0, 2'd1, 32'h0);
        chk("t1_busy_at_k101", bus.mem_rdata, 32'h05);
        bus_op(1'b1, 1'b0, 2'd1, 32'h0);
        chk("t1_idle_at_k102", bus.mem_rdata, 32'h04);
        drain("t1");

        // back-to-back frames
        dec_starts.delete(); dec_log.delete();
        bus_op(1'b0, 1'b1, 2'd0, 32'hA3);
        bus_op(1'b0, 1'b1, 2'd0, 32'h0F);
        bus_op(1'b0, 1'b1, 2'd0, 32'hFF);
        drain("t2");
        chk("t2_frames", 32'(dec_log.size()), 32'd3);
        chk("t2_byte0", 32'(dec_log[0]), 32'hA3);
        chk("t2_byte1", 32'(dec_log[1]), 32'h0F);
        chk("t2_byte2", 32'(dec_log[2]), 32'hFF);
        chk("t2_gap01", 32'(dec_starts[1] - dec_starts[0]), 32'(FRAME + 1));
        chk("t2_gap12", 32'(dec_starts[2] - dec_starts[1]), 32'(FRAME + 1));
        bus_op(1'b1, 1'b0, 2'd1, 32'h0);
        chk("t2_status_empty", bus.mem_rdata, 32'h04);

        // overflow on the sixth consecutive write
        dec_log.delete();
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) bus_op(1'b0, 1'b1, 2'd0, {24'h0, b[i]});
        bus_op(1'b1, 1'b0, 2'd1, 32'h0);
        chk("t3_status_ovf", bus.mem_rdata, 32'h4B);
        bus_op(1'b1, 1'b0, 2'd1, 32'h0);
        chk("t3_status_cleared", bus.mem_rdata, 32'h43);
        drain("t3");
        chk("t3_frames", 32'(dec_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk("t3_byte", 32'(dec_log[i]), 32'(b[i]));

        // reset in the middle of data bit 3
        bus_op(1'b0, 1'b1, 2'd0, 32'h00);
        k = edge_n;
        wait_edge(k + 45);
        chk("t4_txd_in_frame", 32'(TXD), 32'd0);
        #2 resetn = 1'b0;
        #1;
        chk("t4_txd_async", 32'(TXD), 32'd1);
        chk("t4_rdata_async", bus.mem_rdata, 32'h0);
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        bus_op(1'b1, 1'b0, 2'd1, 32'h0);
        chk("t4_status_after", bus.mem_rdata, 32'h04);
        dec_log.delete();
        repeat (150) @(negedge clk);
        chk("t4_no_frames", 32'(dec_log.size()), 32'd0);

        // push while full in the same cycle as the IDLE pop
        dec_log.delete();
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        bus_op(1'b0, 1'b1, 2'd0, {24'h0, b[0]});
        k = edge_n;
        for (int i = 1; i < 5; i++) bus_op(1'b0, 1'b1, 2'd0, {24'h0, b[i]});
        wait_edge(k + FRAME + 1);
        bus_op(1'b0, 1'b1, 2'd0, {24'h0, b[5]});
        bus_op(1'b1, 1'b0, 2'd1, 32'h0);
        chk("t5_status", bus.mem_rdata, 32'h43);
        drain("t5");
        chk("t5_frames", 32'(dec_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk("t5_byte", 32'(dec_log[i]), 32'(b[i]));

        // unmapped offsets and writes to STATUS
        dec_log.delete();
        bus_op(1'b1, 1'b0, 2'd1, 32'h0);
        chk("t6_status_pre", bus.mem_rdata, 32'h04);
        bus_op(1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF);
        chk("t6_read_ofs2", bus.mem_rdata, 32'h0);
        bus_op(1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF);
        bus_op(1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF);
        bus_op(1'b1, 1'b0, 2'd1, 32'h0);
        chk("t6_status_post", bus.mem_rdata, 32'h04);
        repeat (20) @(negedge clk);
        chk("t6_no_frames", 32'(dec_log.size()), 32'd0);

        // random bus traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.sel       = ($urandom_range(0, 3) != 0);
            bus.mem_rstrb = 1'($urandom);
            bus.mem_wmask = 4'($urandom);
            bus.mem_addr  = $urandom;
            bus.mem_wdata = $urandom;
            @(negedge clk);
        end
        bus.sel = 1'b0; bus.mem_rstrb = 1'b0; bus.mem_wmask = 4'h0;
        drain("rand");
        chk("final_pending", 32'(m_sent.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
